verbus_arbiter: RTL and testbench

VERBUS_ARBITER -- requirements
Module: verbus_arbiter

---
 rtl/verdata_pkg.sv | 19 +
 rtl/verbus_timeout_counter.sv | 37 +++
 rtl/verbus_arbiter.sv | 136 +++++++++++++
 tb/tb_verbus_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/verdata_pkg.sv
// Shared types and constants for the verbus arbiter slice.
// Word and strobe widths are common to every CPU-side and target-side bus.
package Verdata_pkg;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  wstrobe_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } verbus_state_e;

  // Read data returned to a master whose transfer was force-completed.
  localparam word_t TimeoutRdata = 32'h0000_0000;

  localparam int unsigned CntWidth = 16;

endpackage

// File: rtl/verbus_timeout_counter.sv
// Counts BUSY cycles without a target response; flags when the count reaches the limit.
// A zero limit never expires.
module verbus_timeout_counter
  import Verdata_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                enable,
  input  logic [CntWidth-1:0] limit,
  output logic                expired
);

  localparam logic [CntWidth-1:0] CntOne = 1;

  logic [CntWidth-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + CntOne;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (limit != '0) && (count_q == limit);

endmodule

// File: rtl/verbus_arbiter.sv
// Two-master (ibus/dbus) to single-target bus arbiter with optional round-robin
// and optional forced completion of stalled transfers.
module verbus_arbiter
  import Verdata_pkg::*;
#(
  parameter int unsigned ROUND_ROBIN = 0,
  parameter int unsigned TIMEOUT     = 0
) (
  input  logic     clk,
  input  logic     reset,
  // Instruction bus (read-only master)
  input  logic     i_valid,
  input  word_t    i_address,
  output word_t    i_rdata,
  output logic     i_ready,
  output logic     i_irq,
  // Data bus (read-write master)
  input  logic     d_valid,
  input  word_t    d_address,
  input  wstrobe_t d_wstrobe,
  input  word_t    d_wdata,
  output word_t    d_rdata,
  output logic     d_ready,
  output logic     d_irq,
  // Target bus
  output logic     s_valid,
  output word_t    s_address,
  output wstrobe_t s_wstrobe,
  output word_t    s_wdata,
  input  word_t    s_rdata,
  input  logic     s_ready,
  input  logic     s_irq,
  output logic     timeout_flag
);

  localparam logic [CntWidth-1:0] Limit = CntWidth'(TIMEOUT);

  verbus_state_e state_q, state_d;
  logic          last_d_q, last_d_d;  // 1: dbus was granted last
  logic          flag_q, flag_d;

  logic grant_i, grant_d, busy;
  logic m_valid, hit, done, grant;
  logic expired;

  always_comb begin
    grant_i = (state_q == BUSY_I);
    grant_d = (state_q == BUSY_D);
    busy    = grant_i | grant_d;
    m_valid = (grant_i & i_valid) | (grant_d & d_valid);
    hit     = busy & expired;
    // Reset abandons the transfer, so no ready may escape in that cycle.
    done    = m_valid & (s_ready | hit) & ~reset;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (i_valid && d_valid) begin
          state_d = ((ROUND_ROBIN != 0) && last_d_q) ? BUSY_I : BUSY_D;
        end else if (d_valid) begin
          state_d = BUSY_D;
        end else if (i_valid) begin
          state_d = BUSY_I;
        end
      end
      BUSY_I: begin
        if (!i_valid) begin
          state_d = IDLE;
        end else if (done) begin
          state_d = d_valid ? BUSY_D : IDLE;
        end
      end
      BUSY_D: begin
        if (!d_valid) begin
          state_d = IDLE;
        end else if (done) begin
          state_d = i_valid ? BUSY_I : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    grant    = (state_d != IDLE) && (state_d != state_q);
    last_d_d = grant ? (state_d == BUSY_D) : last_d_q;
    flag_d   = flag_q | (m_valid & hit);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      flag_q   <= flag_d;
    end
  end

  verbus_timeout_counter u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (grant),
    .enable  (busy & ~s_ready & (Limit != '0)),
    .limit   (Limit),
    .expired (expired)
  );

  always_comb begin
    s_valid   = m_valid & ~hit;
    s_address = '0;
    s_wstrobe = '0;
    s_wdata   = '0;
    i_ready   = grant_i & done;
    d_ready   = grant_d & done;
    i_rdata   = '0;
    d_rdata   = '0;
    if (grant_i) begin
      s_address = i_address;
      i_rdata   = hit ? TimeoutRdata : s_rdata;
    end
    if (grant_d) begin
      s_address = d_address;
      s_wstrobe = d_wstrobe;
      s_wdata   = d_wdata;
      d_rdata   = hit ? TimeoutRdata : s_rdata;
    end
  end

  assign i_irq        = s_irq;
  assign d_irq        = s_irq;
  assign timeout_flag = flag_q;

endmodule

// File: tb/tb_verbus_arbiter.sv
// Bench for verbus_arbiter: a fixed-priority and a round-robin/timeout instance share stimulus
// and are compared each cycle against a transaction-level reference model.
module tb_verbus_arbiter;
  import Verdata_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic     reset, i_valid, d_valid, s_ready, s_irq;
  word_t    i_address, d_address, d_wdata, s_rdata;
  wstrobe_t d_wstrobe;

  logic     f_s_valid, f_i_ready, f_d_ready, f_i_irq, f_d_irq, f_flag;
  word_t    f_s_address, f_s_wdata, f_i_rdata, f_d_rdata;
  wstrobe_t f_s_wstrobe;
  logic     r_s_valid, r_i_ready, r_d_ready, r_i_irq, r_d_irq, r_flag;
  word_t    r_s_address, r_s_wdata, r_i_rdata, r_d_rdata;
  wstrobe_t r_s_wstrobe;

  verbus_arbiter #(.ROUND_ROBIN(0), .TIMEOUT(0)) u_fix (
    .clk(clk), .reset(reset),
    .i_valid(i_valid), .i_address(i_address), .i_rdata(f_i_rdata), .i_ready(f_i_ready),
    .i_irq(f_i_irq),
    .d_valid(d_valid), .d_address(d_address), .d_wstrobe(d_wstrobe), .d_wdata(d_wdata),
    .d_rdata(f_d_rdata), .d_ready(f_d_ready), .d_irq(f_d_irq),
    .s_valid(f_s_valid), .s_address(f_s_address), .s_wstrobe(f_s_wstrobe), .s_wdata(f_s_wdata),
    .s_rdata(s_rdata), .s_ready(s_ready), .s_irq(s_irq), .timeout_flag(f_flag)
  );

  verbus_arbiter #(.ROUND_ROBIN(1), .TIMEOUT(3)) u_rr (
    .clk(clk), .reset(reset),
    .i_valid(i_valid), .i_address(i_address), .i_rdata(r_i_rdata), .i_ready(r_i_ready),
    .i_irq(r_i_irq),
    .d_valid(d_valid), .d_address(d_address), .d_wstrobe(d_wstrobe), .d_wdata(d_wdata),
    .d_rdata(r_d_rdata), .d_ready(r_d_ready), .d_irq(r_d_irq),
    .s_valid(r_s_valid), .s_address(r_s_address), .s_wstrobe(r_s_wstrobe), .s_wdata(r_s_wdata),
    .s_rdata(s_rdata), .s_ready(s_ready), .s_irq(s_irq), .timeout_flag(r_flag)
  );

  typedef struct packed {
    logic     s_valid;
    word_t    s_address;
    wstrobe_t s_wstrobe;
    word_t    s_wdata;
    logic     i_ready;
    word_t    i_rdata;
    logic     d_ready;
    word_t    d_rdata;
    logic     i_irq;
    logic     d_irq;
    logic     flag;
  } out_t;

  out_t act_f, act_r;
  assign act_f = {f_s_valid, f_s_address, f_s_wstrobe, f_s_wdata, f_i_ready, f_i_rdata,
                  f_d_ready, f_d_rdata, f_i_irq, f_d_irq, f_flag};
  assign act_r = {r_s_valid, r_s_address, r_s_wstrobe, r_s_wdata, r_i_ready, r_i_rdata,
                  r_d_ready, r_d_rdata, r_i_irq, r_d_irq, r_flag};

  // owner: 0 nobody, 1 ibus, 2 dbus; waited: stalled BUSY cycles since the grant
  typedef struct {
    int rr;
    int tmo;
    int owner;
    int last;
    int waited;
    bit flag;
  } mdl_t;

  mdl_t mf, mr;
  int checks = 0;
  int errors = 0;

  function automatic logic owner_valid(input int owner);
    return (owner == 1) ? i_valid : (owner == 2) ? d_valid : 1'b0;
  endfunction

  function automatic logic timed_out(input mdl_t m);
    return (m.tmo > 0) && (m.owner != 0) && (m.waited == m.tmo);
  endfunction

  function automatic out_t mexp(input mdl_t m);
    out_t o;
    logic mv, hit, fin;
    mv  = owner_valid(m.owner);
    hit = timed_out(m);
    fin = mv && (s_ready || hit) && !reset;
    o = '0;
    o.s_valid = mv && !hit;
    if (m.owner == 1) begin
      o.s_address = i_address;
      o.i_ready   = fin;
      o.i_rdata   = hit ? 32'h0 : s_rdata;
    end else if (m.owner == 2) begin
      o.s_address = d_address;
      o.s_wstrobe = d_wstrobe;
      o.s_wdata   = d_wdata;
      o.d_ready   = fin;
      o.d_rdata   = hit ? 32'h0 : s_rdata;
    end
    o.i_irq = s_irq;
    o.d_irq = s_irq;
    o.flag  = m.flag;
    return o;
  endfunction

  function automatic mdl_t madv(input mdl_t m);
    mdl_t n;
    logic mv, hit;
    n = m;
    if (reset) begin
      n.owner = 0; n.last = 1; n.waited = 0; n.flag = 1'b0;
      return n;
    end
    mv  = owner_valid(m.owner);
    hit = timed_out(m);
    if (mv && hit) n.flag = 1'b1;
    if (m.owner != 0 && !s_ready) n.waited = m.waited + 1;
    if (m.owner == 0) begin
      if (i_valid && d_valid) n.owner = (m.rr != 0 && m.last == 2) ? 1 : 2;
      else if (d_valid)       n.owner = 2;
      else if (i_valid)       n.owner = 1;
    end else if (!mv) begin
      n.owner = 0;
    end else if (s_ready || hit) begin
      n.owner = owner_valid(3 - m.owner) ? 3 - m.owner : 0;
    end
    if (n.owner != 0 && n.owner != m.owner) begin
      n.waited = 0;
      n.last   = n.owner;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmp(input string nm, input out_t a, input out_t e);
    chk({nm, ".s_valid"},   32'(a.s_valid),   32'(e.s_valid));
    chk({nm, ".s_address"}, a.s_address,      e.s_address);
    chk({nm, ".s_wstrobe"}, 32'(a.s_wstrobe), 32'(e.s_wstrobe));
    chk({nm, ".s_wdata"},   a.s_wdata,        e.s_wdata);
    chk({nm, ".i_ready"},   32'(a.i_ready),   32'(e.i_ready));
    chk({nm, ".i_rdata"},   a.i_rdata,        e.i_rdata);
    chk({nm, ".d_ready"},   32'(a.d_ready),   32'(e.d_ready));
    chk({nm, ".d_rdata"},   a.d_rdata,        e.d_rdata);
    chk({nm, ".i_irq"},     32'(a.i_irq),     32'(e.i_irq));
    chk({nm, ".d_irq"},     32'(a.d_irq),     32'(e.d_irq));
    chk({nm, ".flag"},      32'(a.flag),      32'(e.flag));
  endtask

  task automatic sample();
    @(negedge clk);
    cmp("fix", act_f, mexp(mf));
    cmp("rr", act_r, mexp(mr));
  endtask

  task automatic tick();
    @(posedge clk);
    mf = madv(mf);
    mr = madv(mr);
    #1;
    s_irq = ~s_irq;
  endtask

  task automatic cyc();
    sample();
    tick();
  endtask

  initial begin
    mf = '{0, 0, 0, 1, 0, 1'b0};
    mr = '{1, 3, 0, 1, 0, 1'b0};
    reset = 1'b1; i_valid = 1'b0; d_valid = 1'b0; s_ready = 1'b0; s_irq = 1'b0;
    i_address = '0; d_address = '0; d_wstrobe = '0; d_wdata = '0; s_rdata = '0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    sample();
    chk("reset.f_s_valid", 32'(f_s_valid), 32'd0);
    chk("reset.r_flag", 32'(r_flag), 32'd0);
    tick();

    // ibus alone, response on 2nd BUSY cycle
    i_valid = 1'b1; i_address = 32'h10; s_rdata = 32'h00A0_0213;
    cyc();
    sample();
    chk("ibus.s_address", f_s_address, 32'h10);
    chk("ibus.s_wstrobe", 32'(f_s_wstrobe), 32'd0);
    chk("ibus.i_ready_wait", 32'(f_i_ready), 32'd0);
    tick();
    s_ready = 1'b1;
    sample();
    chk("ibus.i_ready", 32'(f_i_ready), 32'd1);
    chk("ibus.i_rdata", f_i_rdata, 32'h00A0_0213);
    tick();
    s_ready = 1'b0;
    sample();
    chk("ibus.idle_s_valid", 32'(f_s_valid), 32'd0);
    tick();
    i_valid = 1'b0;
    cyc();

    // Contention, fixed priority: dbus first, then ibus with no bubble
    i_valid = 1'b1; i_address = 32'h44; d_valid = 1'b1; d_address = 32'hA100;
    d_wstrobe = 4'b1111; d_wdata = 32'h96;
    cyc();
    sample();
    chk("prio.s_address", f_s_address, 32'hA100);
    chk("prio.s_wstrobe", 32'(f_s_wstrobe), 32'hF);
    chk("prio.s_wdata", f_s_wdata, 32'h96);
    tick();
    s_ready = 1'b1;
    sample();
    chk("prio.d_ready", 32'(f_d_ready), 32'd1);
    tick();
    s_ready = 1'b0; d_valid = 1'b0;
    sample();
    chk("prio.nobubble_s_valid", 32'(f_s_valid), 32'd1);
    chk("prio.nobubble_s_address", f_s_address, 32'h44);
    tick();
    s_ready = 1'b1;
    cyc();
    i_valid = 1'b0; s_ready = 1'b0;
    cyc();

    // Round robin: a dbus-only transfer first, then continuous contention gives I, D, I, D
    d_valid = 1'b1; s_ready = 1'b1;
    cyc();
    cyc();
    d_valid = 1'b0;
    cyc();
    i_valid = 1'b1; d_valid = 1'b1;
    cyc();
    for (int k = 0; k < 4; k++) begin
      sample();
      chk("rr.i_ready", 32'(r_i_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr.d_ready", 32'(r_d_ready), (k % 2 == 0) ? 32'd0 : 32'd1);
      tick();
    end
    i_valid = 1'b0; d_valid = 1'b0; s_ready = 1'b0;
    cyc();
    cyc();

    // Timeout: dbus stalled, forced completion on the 4th BUSY cycle
    d_valid = 1'b1; s_rdata = 32'hDEAD_BEEF;
    cyc();
    for (int k = 1; k <= 4; k++) begin
      sample();
      chk("tmo.d_ready", 32'(r_d_ready), (k == 4) ? 32'd1 : 32'd0);
      if (k == 4) chk("tmo.d_rdata", r_d_rdata, 32'd0);
      tick();
    end
    d_valid = 1'b0;
    sample();
    chk("tmo.flag", 32'(r_flag), 32'd1);
    tick();
    cyc();
    sample();
    chk("tmo.flag_sticky", 32'(r_flag), 32'd1);
    tick();

    // Reset in the middle of a dbus transfer
    d_valid = 1'b1;
    cyc();
    reset = 1'b1; s_ready = 1'b1;
    sample();
    chk("rst.f_d_ready", 32'(f_d_ready), 32'd0);
    chk("rst.r_d_ready", 32'(r_d_ready), 32'd0);
    tick();
    reset = 1'b0; s_ready = 1'b0; d_valid = 1'b0;
    sample();
    chk("rst.s_valid", 32'(r_s_valid), 32'd0);
    chk("rst.flag", 32'(r_flag), 32'd0);
    tick();

    // Randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      reset     = ($urandom_range(0, 63) == 0);
      i_valid   = ($urandom_range(0, 3) != 0);
      d_valid   = ($urandom_range(0, 3) != 0);
      i_address = $urandom;
      d_address = $urandom;
      d_wstrobe = 4'($urandom);
      d_wdata   = $urandom;
      s_rdata   = $urandom;
      s_ready   = ($urandom_range(0, 2) == 0);
      s_irq     = 1'($urandom);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
